// File: rtl/product_bcd_display_if.sv
// product_bcd_display_if: product capture inputs and BCD/seven-segment display outputs
// master drives done_flag/d_in and observes results; slave is the display block
interface product_bcd_display_if;
    logic        done_flag;
    logic [15:0] d_in;
    logic [19:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [7:0]  seg_data;
    logic [7:0]  seg_digit;
    modport master (output done_flag, d_in, input bcd, bcd_valid, busy, seg_data, seg_digit);
    modport slave (input done_flag, d_in, output bcd, bcd_valid, busy, seg_data, seg_digit);
endinterface

// File: rtl/product_bcd_display.sv
// product_bcd_display: captures product on done_flag rise, double-dabbles it to 5 BCD digits, scans a 5-digit active-low display
// Ports: clk, rst (sync active-high), bus (slave modport: done_flag, d_in in; bcd, bcd_valid, busy, seg_data, seg_digit out)
// Option: define PRODUCT_BCD_LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0
module product_bcd_display #(
    parameter int SCAN_DIV = 50000
) (
    input logic clk,
    input logic rst,
    product_bcd_display_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    typedef enum logic {IDLE, CONV} state_t;
    state_t state, state_next;
    logic done_q, rise, valid_r, blank;
    logic [35:0] sr, adj, shifted;
    logic [3:0] cnt, nib;
    logic [19:0] bcd_r;
    logic [PW-1:0] pre;
    logic [2:0] idx;
    assign rise = bus.done_flag & ~done_q;
    always_comb begin
        adj = sr;
        for (int i = 0; i < 5; i++)
            adj[16+4*i +: 4] = sr[16+4*i +: 4] + (sr[16+4*i +: 4] >= 4'd5 ? 4'd3 : 4'd0);
        shifted = adj << 1;
    end
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        if (state == IDLE) state_next = rise ? CONV : IDLE;
        else state_next = cnt == 4'd15 ? IDLE : CONV;
    end
    always_ff @(posedge clk)
        if (rst) begin
            done_q  <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            bcd_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            done_q  <= bus.done_flag;
            valid_r <= state == CONV && cnt == 4'd15;
            if (state == IDLE && rise) begin
                sr  <= {20'b0, bus.d_in};
                cnt <= '0;
            end else if (state == CONV) begin
                sr  <= shifted;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) bcd_r <= shifted[35:16];
            end
        end
    always_ff @(posedge clk)
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
        end else pre <= pre + 1'b1;
    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'd0: dec = 8'hC0;
            4'd1: dec = 8'hF9;
            4'd2: dec = 8'hA4;
            4'd3: dec = 8'hB0;
            4'd4: dec = 8'h99;
            4'd5: dec = 8'h92;
            4'd6: dec = 8'h82;
            4'd7: dec = 8'hF8;
            4'd8: dec = 8'h80;
            4'd9: dec = 8'h90;
            default: dec = 8'hFF;
        endcase
    endfunction
    always_comb begin
        nib = idx == 3'd0 ? bcd_r[3:0] : idx == 3'd1 ? bcd_r[7:4] : idx == 3'd2 ? bcd_r[11:8] :
              idx == 3'd3 ? bcd_r[15:12] : bcd_r[19:16];
`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
        blank = (idx == 3'd1 && bcd_r[19:4] == '0) || (idx == 3'd2 && bcd_r[19:8] == '0) ||
                (idx == 3'd3 && bcd_r[19:12] == '0) || (idx == 3'd4 && bcd_r[19:16] == '0);
`else
        blank = 1'b0;
`endif
        bus.seg_data  = blank ? 8'hFF : dec(nib);
        bus.seg_digit = ~(8'b1 << idx);
        bus.busy      = state == CONV;
        bus.bcd       = bcd_r;
        bus.bcd_valid = valid_r;
    end
endmodule

// File: tb/tb_product_bcd_display.sv
// tb_product_bcd_display: directed self-checking bench for product_bcd_display with SCAN_DIV=4
module tb_product_bcd_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int busy_n, valid_n;
    logic [19:0] bcd_at_valid;
    product_bcd_display_if bus();
    product_bcd_display #(.SCAN_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic wait_digit(input logic [7:0] d);
        int n;
        n = 0;
        while (bus.seg_digit !== d && n < 40) begin
            tick();
            n++;
        end
        chk("wait_digit", {24'b0, bus.seg_digit}, {24'b0, d});
    endtask
    task automatic run_conv(input logic [15:0] v);
        bus.d_in = v;
        bus.done_flag = 1'b1;
        tick();
        bus.done_flag = 1'b0;
        busy_n = 0;
        valid_n = 0;
        bcd_at_valid = '0;
        for (int i = 0; i < 30; i++) begin
            if (bus.busy) busy_n++;
            if (bus.bcd_valid) begin
                valid_n++;
                bcd_at_valid = bus.bcd;
            end
            tick();
        end
    endtask
    initial begin
        logic [7:0] dig [5];
        logic [7:0] seg [5];
        dig = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF};
        bus.done_flag = 1'b0;
        bus.d_in = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_seg_digit", {24'b0, bus.seg_digit}, 32'hFE);
        chk("reset_seg_data", {24'b0, bus.seg_data}, 32'hC0);
        chk("reset_bcd", {12'b0, bus.bcd}, 32'h0);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("reset_valid", {31'b0, bus.bcd_valid}, 32'h0);
        run_conv(16'hFFFF);
        chk("full_busy_cycles", busy_n, 16);
        chk("full_valid_pulses", valid_n, 1);
        chk("full_bcd_at_valid", {12'b0, bcd_at_valid}, 32'h65535);
        chk("full_bcd_held", {12'b0, bus.bcd}, 32'h65535);
        run_conv(16'h00E1);
        chk("blank_bcd", {12'b0, bus.bcd}, 32'h00225);
`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
        seg = '{8'h92, 8'hA4, 8'hA4, 8'hFF, 8'hFF};
`else
        seg = '{8'h92, 8'hA4, 8'hA4, 8'hC0, 8'hC0};
`endif
        for (int k = 0; k < 5; k++) begin
            wait_digit(dig[k]);
            chk("blank_seg", {24'b0, bus.seg_data}, {24'b0, seg[k]});
        end
        bus.d_in = 16'd1234;
        bus.done_flag = 1'b1;
        valid_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.bcd_valid) valid_n++;
        end
        bus.done_flag = 1'b0;
        tick();
        chk("held_valid_pulses", valid_n, 1);
        chk("held_bcd", {12'b0, bus.bcd}, 32'h01234);
        bus.d_in = 16'd4321;
        bus.done_flag = 1'b1;
        tick();
        bus.done_flag = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.done_flag = 1'b1;
        bus.d_in = 16'd100;
        valid_n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.bcd_valid) valid_n++;
        end
        bus.done_flag = 1'b0;
        tick();
        chk("retrig_valid_pulses", valid_n, 1);
        chk("retrig_bcd", {12'b0, bus.bcd}, 32'h04321);
        chk("retrig_idle", {31'b0, bus.busy}, 32'h0);
        bus.d_in = 16'd12345;
        bus.done_flag = 1'b1;
        tick();
        bus.done_flag = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_busy_before_rst", {31'b0, bus.busy}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("mid_rst_bcd", {12'b0, bus.bcd}, 32'h0);
        valid_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.bcd_valid) valid_n++;
            tick();
        end
        chk("mid_rst_no_valid", valid_n, 0);
        bus.done_flag = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.done_flag = 1'b0;
        tick();
        chk("rst_beats_rise", {31'b0, bus.busy}, 32'h0);
        run_conv(16'd12345);
        chk("after_rst_valid", valid_n, 1);
        chk("after_rst_bcd", {12'b0, bus.bcd}, 32'h12345);
        seg = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        wait_digit(8'hFD);
        wait_digit(8'hFE);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk("scan_digit", {24'b0, bus.seg_digit}, {24'b0, dig[k % 5]});
                if (j == 0) chk("scan_seg", {24'b0, bus.seg_data}, {24'b0, seg[k % 5]});
                tick();
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
